// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Register word bit positions, FSM states and the power-on init command ROM.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRON,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    localparam int BIT_ON   = 31;
    localparam int BIT_BLON = 30;
    localparam int BIT_GO   = 10;
    localparam int BIT_RS   = 9;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam int         INIT_LEN = 6;
    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    // 8-bit bus, 2 lines; display on; clear; entry mode increment
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            default:          init_rom = 8'h06;
        endcase
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        is_long_cmd = !rs && ((data == OP_CLEAR) || (data == OP_HOME));
    endfunction

    function automatic int max_int(input int a, input int b);
        max_int = (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used to time every LCD bus phase.
// done_o is high while the count is zero; a load always takes priority.
module lcd_delay_cnt #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RESET_VAL;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 controller: power-on init, then one timed bus write per GO edge
// of the LSU register word, with a one-deep pending slot for early requests.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_PWRON_CYC = 750000,
    parameter int T_SETUP_CYC = 2,
    parameter int T_EN_CYC    = 12,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_blon_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        overrun_o
);

    localparam int MAX_CYC = max_int(max_int(max_int(T_PWRON_CYC, T_SETUP_CYC),
                                             max_int(T_EN_CYC, T_HOLD_CYC)),
                                     max_int(T_CMD_CYC, T_CLR_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    lcd_state_e       state_q;
    logic [2:0]       init_idx_q;
    logic             prev_go_q;
    logic             pend_valid_q;
    logic             pend_rs_q;
    logic [7:0]       pend_data_q;

    logic             go_req;
    logic             init_more;
    logic             take_pend;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;
    logic             unused_word;

    assign go_req      = lcd_word_i[BIT_GO] & ~prev_go_q;
    assign init_more   = (init_idx_q < 3'(INIT_LEN - 1));
    assign lcd_rw_o    = 1'b0;
    assign unused_word = ^{lcd_word_i[29:11], lcd_word_i[8]};

    lcd_delay_cnt #(
        .W         (CNT_W),
        .RESET_VAL (CNT_W'(T_PWRON_CYC - 1))
    ) u_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (cnt_load),
        .value_i (cnt_value),
        .done_o  (cnt_done)
    );

    // Phase length for the state being entered; a phase of N cycles loads N-1.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        take_pend = 1'b0;
        case (state_q)
            ST_INIT_LOAD: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(T_SETUP_CYC - 1);
            end
            ST_SETUP: if (cnt_done) begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(T_EN_CYC - 1);
            end
            ST_EN_HI: if (cnt_done) begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(T_HOLD_CYC - 1);
            end
            ST_HOLD: if (cnt_done) begin
                cnt_load  = 1'b1;
                cnt_value = is_long_cmd(lcd_rs_o, lcd_data_o) ? CNT_W'(T_CLR_CYC - 1)
                                                               : CNT_W'(T_CMD_CYC - 1);
            end
            ST_WAIT: if (cnt_done && !init_more && pend_valid_q) begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(T_SETUP_CYC - 1);
                take_pend = 1'b1;
            end
            ST_IDLE: if (pend_valid_q) begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(T_SETUP_CYC - 1);
                take_pend = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_PWRON;
            init_idx_q   <= 3'd0;
            prev_go_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_rs_q    <= 1'b0;
            pend_data_q  <= 8'h00;
            lcd_on_o     <= 1'b0;
            lcd_blon_o   <= 1'b0;
            lcd_en_o     <= 1'b0;
            lcd_rs_o     <= 1'b0;
            lcd_data_o   <= 8'h00;
            busy_o       <= 1'b0;
            init_done_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            lcd_on_o   <= lcd_word_i[BIT_ON];
            lcd_blon_o <= lcd_word_i[BIT_BLON];
            prev_go_q  <= lcd_word_i[BIT_GO];

            // A request landing on the cycle the slot drains is not an overrun
            if (go_req) begin
                pend_rs_q   <= lcd_word_i[BIT_RS];
                pend_data_q <= lcd_word_i[DATA_MSB:DATA_LSB];
            end
            if (go_req && pend_valid_q && !take_pend) begin
                overrun_o <= 1'b1;
            end
            pend_valid_q <= go_req | (pend_valid_q & ~take_pend);

            busy_o <= 1'b1;
            case (state_q)
                ST_PWRON: if (cnt_done) begin
                    state_q    <= ST_INIT_LOAD;
                    init_idx_q <= 3'd0;
                end
                ST_INIT_LOAD: begin
                    lcd_rs_o   <= 1'b0;
                    lcd_data_o <= init_rom(init_idx_q);
                    state_q    <= ST_SETUP;
                end
                ST_SETUP: if (cnt_done) begin
                    lcd_en_o <= 1'b1;
                    state_q  <= ST_EN_HI;
                end
                ST_EN_HI: if (cnt_done) begin
                    lcd_en_o <= 1'b0;
                    state_q  <= ST_HOLD;
                end
                ST_HOLD: if (cnt_done) begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: if (cnt_done) begin
                    if (init_more) begin
                        init_idx_q <= init_idx_q + 3'd1;
                        state_q    <= ST_INIT_LOAD;
                    end else begin
                        init_done_o <= 1'b1;
                        if (pend_valid_q) begin
                            lcd_rs_o   <= pend_rs_q;
                            lcd_data_o <= pend_data_q;
                            state_q    <= ST_SETUP;
                        end else begin
                            busy_o  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (pend_valid_q) begin
                        lcd_rs_o   <= pend_rs_q;
                        lcd_data_o <= pend_data_q;
                        state_q    <= ST_SETUP;
                    end else begin
                        busy_o <= 1'b0;
                    end
                end
                default: state_q <= ST_PWRON;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: bus-cycle monitor compared against a
// timing model built from edge arithmetic over the request history.
module tb_lcd_ctrl;

    localparam int T_PWRON = 20;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int T_CMD   = 10;
    localparam int T_CLR   = 40;
    localparam int NEVER   = 32'h3fff_ffff;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] lcd_word;
    logic        lcd_on_o, lcd_blon_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
    logic [7:0]  lcd_data_o;
    logic        busy_o, init_done_o, overrun_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          edge_n;
    logic [1:0]  on_bits;

    typedef struct { logic rs; logic [7:0] data; int rise; } exp_t;
    typedef struct { logic rs; logic [7:0] data; int width; int rise; bit unstable; } obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];
    obs_t cur;
    logic en_prev = 1'b0;

    // Model state: edge at which the bus frees up, and the one-deep slot
    int          m_free;
    bit          m_slot;
    logic        m_rs;
    logic [7:0]  m_data;
    int          m_fill;
    bit          m_overrun;

    lcd_ctrl #(
        .T_PWRON_CYC (T_PWRON), .T_SETUP_CYC (T_SETUP), .T_EN_CYC (T_EN),
        .T_HOLD_CYC  (T_HOLD),  .T_CMD_CYC   (T_CMD),   .T_CLR_CYC (T_CLR)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .lcd_word_i  (lcd_word),
        .lcd_on_o    (lcd_on_o),
        .lcd_blon_o  (lcd_blon_o),
        .lcd_en_o    (lcd_en_o),
        .lcd_rs_o    (lcd_rs_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_data_o  (lcd_data_o),
        .busy_o      (busy_o),
        .init_done_o (init_done_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    // Bus monitor: one record per EN pulse, tagged with the edge EN rose on
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            en_prev = 1'b0;
        end else begin
            if (lcd_en_o && !en_prev) begin
                cur.rs = lcd_rs_o; cur.data = lcd_data_o;
                cur.width = 1; cur.rise = edge_n; cur.unstable = 1'b0;
            end else if (lcd_en_o) begin
                cur.width++;
                if (lcd_rs_o !== cur.rs || lcd_data_o !== cur.data) cur.unstable = 1'b1;
            end else if (en_prev) begin
                obs_q.push_back(cur);
            end
            en_prev = lcd_en_o;
        end
    end

    function automatic int xferLen(input logic rs, input logic [7:0] d);
        return T_SETUP + T_EN + T_HOLD + ((!rs && (d == 8'h01 || d == 8'h02)) ? T_CLR : T_CMD);
    endfunction

    function automatic void modelStart(input logic rs, input logic [7:0] d, input int take);
        exp_t e;
        e.rs = rs; e.data = d; e.rise = take + T_SETUP;
        exp_q.push_back(e);
        m_free = take + xferLen(rs, d);
    endfunction

    function automatic void modelResolve(input int k);
        int take;
        if (m_slot) begin
            take = (m_fill + 1 > m_free) ? m_fill + 1 : m_free;
            if (take <= k) begin
                modelStart(m_rs, m_data, take);
                m_slot = 1'b0;
            end
        end
    endfunction

    function automatic void modelRequest(input int k, input logic rs, input logic [7:0] d);
        modelResolve(k);
        if (m_slot) m_overrun = 1'b1;
        m_slot = 1'b1; m_rs = rs; m_data = d; m_fill = k;
    endfunction

    // Power-on wait, then six init commands each preceded by a one-cycle load
    function automatic void modelReset();
        logic [7:0] rom [6];
        int take;
        rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        exp_q.delete();
        m_slot = 1'b0; m_overrun = 1'b0;
        take = T_PWRON + 1;
        for (int i = 0; i < 6; i++) begin
            modelStart(1'b0, rom[i], take);
            take = m_free + 1;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        @(negedge clk_i);
        lcd_word = w;
    endtask

    task automatic sendReq(input logic rs, input logic [7:0] d);
        applyStimulus({on_bits, 19'd0, 1'b1, rs, 1'b0, d});
        modelRequest(edge_n + 1, rs, d);
        applyStimulus({on_bits, 19'd0, 1'b0, rs, 1'b0, d});
    endtask

    task automatic waitEdge(input int target);
        int guard = 0;
        while (edge_n < target && guard < 5000) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 5000) checkOutput("wait_timeout", edge_n, target);
    endtask

    task automatic waitEn(input string tag);
        int guard = 0;
        while (!lcd_en_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        checkOutput(tag, lcd_en_o, 1'b1);
    endtask

    task automatic waitIdle();
        modelResolve(NEVER);
        waitEdge(m_free + 2);
    endtask

    task automatic compareQueues(input string tag);
        checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput($sformatf("%s_rs%0d", tag, i),    obs_q[i].rs,       exp_q[i].rs);
            checkOutput($sformatf("%s_data%0d", tag, i),  obs_q[i].data,     exp_q[i].data);
            checkOutput($sformatf("%s_width%0d", tag, i), obs_q[i].width,    T_EN);
            checkOutput($sformatf("%s_rise%0d", tag, i),  obs_q[i].rise,     exp_q[i].rise);
            checkOutput($sformatf("%s_stable%0d", tag, i), obs_q[i].unstable, 1'b0);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [15:0] allOutputs();
        return {lcd_on_o, lcd_blon_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o,
                busy_o, init_done_o, overrun_o};
    endfunction

    initial begin
        int busy_cycles;
        rst_ni   = 1'b0;
        on_bits  = 2'b00;
        lcd_word = 32'h0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_outputs", allOutputs(), 16'h0);

        $display("[TB] init sequence with a request held during init");
        @(negedge clk_i);
        rst_ni = 1'b1;
        modelReset();
        waitEdge(40);
        sendReq(1'b1, 8'h80);
        waitIdle();
        compareQueues("init");
        checkOutput("init_done", init_done_o, 1'b1);
        checkOutput("idle_busy", busy_o, 1'b0);
        checkOutput("no_overrun", overrun_o, m_overrun);

        $display("[TB] single data write");
        sendReq(1'b1, 8'h41);
        busy_cycles = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (busy_o) busy_cycles++;
        end
        checkOutput("busy_len", busy_cycles, xferLen(1'b1, 8'h41));
        waitIdle();
        compareQueues("char_A");

        $display("[TB] three requests during one transfer");
        sendReq(1'b1, 8'h31);
        waitEn("wait_en_31");
        sendReq(1'b1, 8'h32);
        sendReq(1'b1, 8'h33);
        waitIdle();
        compareQueues("overrun_seq");
        checkOutput("overrun_flag", overrun_o, m_overrun);

        $display("[TB] power and backlight bits");
        on_bits = 2'b11;
        applyStimulus({on_bits, 30'd0});
        #1;
        checkOutput("on_not_yet", {lcd_on_o, lcd_blon_o}, 2'b00);
        @(negedge clk_i);
        checkOutput("on_blon", {lcd_on_o, lcd_blon_o}, 2'b11);
        repeat (20) @(negedge clk_i);
        checkOutput("on_no_pulse", obs_q.size(), 0);
        checkOutput("on_busy", busy_o, 1'b0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk_i);
            sendReq(1'($urandom_range(0, 1)), 8'($urandom));
        end
        waitIdle();
        compareQueues("random");
        checkOutput("random_overrun", overrun_o, m_overrun);

        $display("[TB] reset during EN pulse");
        sendReq(1'b1, 8'h55);
        waitEn("wait_en_55");
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_reset", allOutputs(), 16'h0);
        obs_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        modelReset();
        waitIdle();
        compareQueues("reinit");
        checkOutput("reinit_done", init_done_o, 1'b1);
        checkOutput("reinit_busy", busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
